// File: rtl/fp_add_align_stage.sv
// -----------------------------------------------------------------------------
// fp_add_align_stage
//
// Pre-add alignment stage of the floating-point adder. It feeds the
// carry-lookahead mantissa adder directly.
// Two operand pairs {sign, exp, man} arrive over a valid/ready handshake.
// The stage orders them by magnitude and right-aligns the smaller significand,
// folding the bits shifted out into the sticky bit. It then presents
// adder-ready operands together with the carry-in, exponent, sign and
// special-case flags.
//
// Pipeline: stage 1 registers the unpack/compare/swap results. Stage 2
// registers the aligned operands. Both stages stall under full backpressure.
// ADD_W must be at least MAN_W+4 so that {hidden, man, G, R, S} fits.
//
// Ports
//   i_clk      clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   i_valid    upstream operand pair valid
//   o_ready    stage can accept a pair this cycle
//   i_op_a     operand A {sign, exp, man}
//   i_op_b     operand B {sign, exp, man}
//   o_valid    aligned result valid
//   i_ready    downstream adder accepts
//   o_a        larger-magnitude significand, aligned {pad, hidden, man, G, R, S}
//   o_b        smaller significand, shifted, inverted on effective subtract
//   o_c_in     adder carry-in (1 on effective subtract)
//   o_exp      larger operand's effective exponent
//   o_sign     result sign
//   o_eff_sub  operand signs differ
//   o_nan      either operand NaN, or Inf minus Inf
//   o_inf      result infinite (non-NaN)
// -----------------------------------------------------------------------------
module fp_add_align_stage #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int ADD_W = 32
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [EXP_W+MAN_W:0] i_op_a,
   input  logic [EXP_W+MAN_W:0] i_op_b,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [ADD_W-1:0]     o_a,
   output logic [ADD_W-1:0]     o_b,
   output logic                 o_c_in,
   output logic [EXP_W-1:0]     o_exp,
   output logic                 o_sign,
   output logic                 o_eff_sub,
   output logic                 o_nan,
   output logic                 o_inf
);

   localparam int SIG_W = MAN_W + 1;   // hidden bit + stored mantissa
   localparam int GRS_W = MAN_W + 4;   // significand plus guard, round, sticky
   localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

   // Place a significand in the adder word with G/R/S cleared and zero padding.
   function automatic logic [ADD_W-1:0] place_sig(input logic [SIG_W-1:0] sig);
      logic [ADD_W-1:0] res;
      res = '0;
      res[GRS_W-1:0] = {sig, 3'b000};
      return res;
   endfunction

   // Right-shift a significand by diff. Every bit that falls off the bottom is
   // ORed into the sticky bit. A shift of GRS_W or more leaves only the sticky
   // bit, because the shift yields zero and the loss mask covers every bit.
   function automatic logic [ADD_W-1:0] align_shift(input logic [SIG_W-1:0] sig,
                                                    input logic [EXP_W-1:0] diff);
      logic [GRS_W-1:0] wide;
      logic [GRS_W-1:0] kept;
      logic [GRS_W-1:0] lost_mask;
      logic [ADD_W-1:0] res;
      wide      = {sig, 3'b000};
      kept      = wide >> diff;
      lost_mask = ~({GRS_W{1'b1}} << diff);
      res       = '0;
      res[GRS_W-1:0] = {kept[GRS_W-1:1], kept[0] | (|(wide & lost_mask))};
      return res;
   endfunction

   // Handshake
   logic w_adv1, w_adv2;
   logic r_vld_p1, r_vld_p2;

   assign w_adv2  = ~r_vld_p2 | i_ready;
   assign w_adv1  = ~r_vld_p1 | w_adv2;
   assign o_ready = w_adv1;
   assign o_valid = r_vld_p2;

   // Unpack
   logic             w_sign_a, w_sign_b;
   logic [EXP_W-1:0] w_exp_a, w_exp_b;
   logic [MAN_W-1:0] w_man_a, w_man_b;
   logic             w_hid_a, w_hid_b;
   logic [EXP_W-1:0] w_eexp_a, w_eexp_b;

   assign {w_sign_a, w_exp_a, w_man_a} = i_op_a;
   assign {w_sign_b, w_exp_b, w_man_b} = i_op_b;
   assign w_hid_a  = |w_exp_a;
   assign w_hid_b  = |w_exp_b;
   // Denormals and zero share effective exponent 1 with no hidden bit.
   assign w_eexp_a = w_hid_a ? w_exp_a : EXP_ONE;
   assign w_eexp_b = w_hid_b ? w_exp_b : EXP_ONE;

   // Magnitude order: swap only on strictly greater B, so ties keep A on top.
   logic             w_swap;
   logic [SIG_W-1:0] w_sig_l, w_sig_s;
   logic [EXP_W-1:0] w_exp_l, w_exp_s;
   logic             w_sign_l;

   assign w_swap   = {w_eexp_b, w_hid_b, w_man_b} > {w_eexp_a, w_hid_a, w_man_a};
   assign w_sig_l  = w_swap ? {w_hid_b, w_man_b} : {w_hid_a, w_man_a};
   assign w_sig_s  = w_swap ? {w_hid_a, w_man_a} : {w_hid_b, w_man_b};
   assign w_exp_l  = w_swap ? w_eexp_b : w_eexp_a;
   assign w_exp_s  = w_swap ? w_eexp_a : w_eexp_b;
   assign w_sign_l = w_swap ? w_sign_b : w_sign_a;

   // Specials. An Inf can never lose the magnitude compare to a finite value,
   // so the larger operand's sign is already the Inf's sign whenever o_inf is set.
   logic w_max_a, w_max_b;
   logic w_nan_a, w_nan_b, w_inf_a, w_inf_b;
   logic w_eff_sub, w_nan, w_inf;

   assign w_max_a   = &w_exp_a;
   assign w_max_b   = &w_exp_b;
   assign w_nan_a   = w_max_a & (|w_man_a);
   assign w_nan_b   = w_max_b & (|w_man_b);
   assign w_inf_a   = w_max_a & ~(|w_man_a);
   assign w_inf_b   = w_max_b & ~(|w_man_b);
   assign w_eff_sub = w_sign_a ^ w_sign_b;
   assign w_nan     = w_nan_a | w_nan_b | (w_inf_a & w_inf_b & w_eff_sub);
   assign w_inf     = ~w_nan & (w_inf_a | w_inf_b);

   // ---- stage 1 boundary: ordered operands, exponent difference, flags ----
   logic [SIG_W-1:0] r_sig_l_p1, r_sig_s_p1;
   logic [EXP_W-1:0] r_exp_p1, r_diff_p1;
   logic             r_sign_p1, r_eff_sub_p1, r_nan_p1, r_inf_p1;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_vld_p1     <= 1'b0;
         r_sig_l_p1   <= '0;
         r_sig_s_p1   <= '0;
         r_exp_p1     <= '0;
         r_diff_p1    <= '0;
         r_sign_p1    <= 1'b0;
         r_eff_sub_p1 <= 1'b0;
         r_nan_p1     <= 1'b0;
         r_inf_p1     <= 1'b0;
      end else if (w_adv1) begin
         r_vld_p1 <= i_valid;
         if (i_valid) begin
            r_sig_l_p1   <= w_sig_l;
            r_sig_s_p1   <= w_sig_s;
            r_exp_p1     <= w_exp_l;
            r_diff_p1    <= w_exp_l - w_exp_s;
            r_sign_p1    <= w_sign_l;
            r_eff_sub_p1 <= w_eff_sub;
            r_nan_p1     <= w_nan;
            r_inf_p1     <= w_inf;
         end
      end
   end

   // Alignment of the smaller significand; subtract uses ~b + 1 in the adder.
   logic [ADD_W-1:0] w_shifted;

   assign w_shifted = align_shift(r_sig_s_p1, r_diff_p1);

   // ---- stage 2 boundary: adder-ready operands ----
   logic [ADD_W-1:0] r_a_p2, r_b_p2;
   logic [EXP_W-1:0] r_exp_p2;
   logic             r_c_in_p2, r_sign_p2, r_eff_sub_p2, r_nan_p2, r_inf_p2;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_vld_p2     <= 1'b0;
         r_a_p2       <= '0;
         r_b_p2       <= '0;
         r_c_in_p2    <= 1'b0;
         r_exp_p2     <= '0;
         r_sign_p2    <= 1'b0;
         r_eff_sub_p2 <= 1'b0;
         r_nan_p2     <= 1'b0;
         r_inf_p2     <= 1'b0;
      end else if (w_adv2) begin
         r_vld_p2 <= r_vld_p1;
         if (r_vld_p1) begin
            r_a_p2       <= place_sig(r_sig_l_p1);
            r_b_p2       <= r_eff_sub_p1 ? ~w_shifted : w_shifted;
            r_c_in_p2    <= r_eff_sub_p1;
            r_exp_p2     <= r_exp_p1;
            r_sign_p2    <= r_sign_p1;
            r_eff_sub_p2 <= r_eff_sub_p1;
            r_nan_p2     <= r_nan_p1;
            r_inf_p2     <= r_inf_p1;
         end
      end
   end

   assign o_a       = r_a_p2;
   assign o_b       = r_b_p2;
   assign o_c_in    = r_c_in_p2;
   assign o_exp     = r_exp_p2;
   assign o_sign    = r_sign_p2;
   assign o_eff_sub = r_eff_sub_p2;
   assign o_nan     = r_nan_p2;
   assign o_inf     = r_inf_p2;

endmodule

// File: tb/tb_fp_add_align_stage.sv
// -----------------------------------------------------------------------------
// tb_fp_add_align_stage
//
// Directed bench for the FP adder alignment stage (single-precision
// configuration). A behavioural model computes each result from operand
// values with plain integer arithmetic. A negedge monitor compares every
// cycle with o_valid high against an in-order queue of model results.
// Hand-computed literals pin both the model and the DUT.
// -----------------------------------------------------------------------------
module tb_fp_add_align_stage;

   localparam int EXP_W = 8;
   localparam int MAN_W = 23;
   localparam int ADD_W = 32;

   logic        clk     = 1'b0;
   logic        rst_n   = 1'b1;
   logic        i_valid = 1'b0;
   logic        i_ready = 1'b1;
   logic [31:0] op_a    = '0;
   logic [31:0] op_b    = '0;
   logic        o_ready, o_valid, o_c_in, o_sign, o_eff_sub, o_nan, o_inf;
   logic [31:0] o_a, o_b;
   logic [7:0]  o_exp;

   int n_cmp = 0;
   int n_bad = 0;
   int n_in  = 0;
   int n_out = 0;

   fp_add_align_stage #(.EXP_W(EXP_W), .MAN_W(MAN_W), .ADD_W(ADD_W)) dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_valid  (i_valid),
      .o_ready  (o_ready),
      .i_op_a   (op_a),
      .i_op_b   (op_b),
      .o_valid  (o_valid),
      .i_ready  (i_ready),
      .o_a      (o_a),
      .o_b      (o_b),
      .o_c_in   (o_c_in),
      .o_exp    (o_exp),
      .o_sign   (o_sign),
      .o_eff_sub(o_eff_sub),
      .o_nan    (o_nan),
      .o_inf    (o_inf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        c_in;
      logic [7:0]  e;
      logic        sign;
      logic        eff_sub;
      logic        nan;
      logic        inf;
   } res_t;

   res_t q[$];

   function automatic res_t mk(input logic [31:0] a, input logic [31:0] b, input logic c,
                               input logic [7:0] e, input logic s, input logic sub,
                               input logic nan, input logic inf);
      res_t r;
      r.a = a; r.b = b; r.c_in = c; r.e = e;
      r.sign = s; r.eff_sub = sub; r.nan = nan; r.inf = inf;
      return r;
   endfunction

   // Behavioural model: values as integers, alignment as divide/remainder.
   function automatic res_t model(input logic [31:0] x, input logic [31:0] y);
      res_t        r;
      int          ex, ey, eex, eey, el, es, d;
      longint      mx, my, sx, sy, sl, ss, grs, kept, lost, shifted;
      logic        swap, x_nan, y_nan, x_inf, y_inf, sl_sign;
      logic [31:0] t;
      ex  = int'(x[30:23]);
      ey  = int'(y[30:23]);
      mx  = longint'(x[22:0]);
      my  = longint'(y[22:0]);
      eex = (ex == 0) ? 1 : ex;
      eey = (ey == 0) ? 1 : ey;
      sx  = ((ex == 0) ? 0 : 8388608) + mx;
      sy  = ((ey == 0) ? 0 : 8388608) + my;
      swap    = (eey > eex) || ((eey == eex) && (sy > sx));
      sl      = swap ? sy : sx;
      ss      = swap ? sx : sy;
      el      = swap ? eey : eex;
      es      = swap ? eex : eey;
      sl_sign = swap ? y[31] : x[31];
      d   = el - es;
      grs = ss * 8;
      if (d >= 27) begin
         kept = 0;
         lost = grs;
      end else begin
         kept = grs / (longint'(1) << d);
         lost = grs % (longint'(1) << d);
      end
      shifted   = kept + (((lost != 0) && (kept % 2 == 0)) ? 1 : 0);
      r.eff_sub = x[31] ^ y[31];
      r.a       = 32'(sl * 8);
      t         = 32'(shifted);
      r.b       = r.eff_sub ? ~t : t;
      r.c_in    = r.eff_sub;
      r.e       = 8'(el);
      x_nan = (ex == 255) && (mx != 0);
      y_nan = (ey == 255) && (my != 0);
      x_inf = (ex == 255) && (mx == 0);
      y_inf = (ey == 255) && (my == 0);
      r.nan  = x_nan || y_nan || (x_inf && y_inf && r.eff_sub);
      r.inf  = !r.nan && (x_inf || y_inf);
      r.sign = r.inf ? (x_inf ? x[31] : y[31]) : sl_sign;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, req);
      end
   endtask

   task automatic cmp_dut(input string nm, input res_t r);
      chk({nm, " o_a"},       o_a,             r.a);
      chk({nm, " o_b"},       o_b,             r.b);
      chk({nm, " o_c_in"},    32'(o_c_in),    32'(r.c_in));
      chk({nm, " o_exp"},     32'(o_exp),     32'(r.e));
      chk({nm, " o_sign"},    32'(o_sign),    32'(r.sign));
      chk({nm, " o_eff_sub"}, 32'(o_eff_sub), 32'(r.eff_sub));
      chk({nm, " o_nan"},     32'(o_nan),     32'(r.nan));
      chk({nm, " o_inf"},     32'(o_inf),     32'(r.inf));
   endtask

   task automatic pin_model(input string nm, input res_t m, input res_t r);
      chk({nm, " model.a"},    m.a,           r.a);
      chk({nm, " model.b"},    m.b,           r.b);
      chk({nm, " model.c_in"}, 32'(m.c_in),   32'(r.c_in));
      chk({nm, " model.exp"},  32'(m.e),      32'(r.e));
      chk({nm, " model.sign"}, 32'(m.sign),   32'(r.sign));
      chk({nm, " model.sub"},  32'(m.eff_sub), 32'(r.eff_sub));
      chk({nm, " model.nan"},  32'(m.nan),    32'(r.nan));
      chk({nm, " model.inf"},  32'(m.inf),    32'(r.inf));
   endtask

   // Monitor: compare on every cycle with valid output; pop on transfer.
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
      end else begin
         if (o_valid) begin
            if (q.size() == 0) begin
               chk("monitor unexpected o_valid", 32'(o_valid), 32'd0);
            end else begin
               cmp_dut("monitor", q[0]);
               if (i_ready) begin
                  void'(q.pop_front());
                  n_out++;
               end
            end
         end
         if (i_valid && o_ready) begin
            q.push_back(model(op_a, op_b));
            n_in++;
         end
      end
   end

   // Offer one pair from posedge+1 until accepted; returns at accept edge + 1.
   task automatic send(input logic [31:0] a, input logic [31:0] b);
      logic acc;
      int   guard;
      op_a = a; op_b = b; i_valid = 1'b1;
      acc = 1'b0; guard = 0;
      do begin
         @(negedge clk);
         acc = o_ready;
         @(posedge clk); #1;
         guard++;
      end while (!acc && guard < 50);
      chk("send accepted", 32'(acc), 32'd1);
      i_valid = 1'b0;
   endtask

   task automatic directed(input string nm, input logic [31:0] a, input logic [31:0] b,
                           input res_t req);
      pin_model(nm, model(a, b), req);
      i_ready = 1'b1;
      send(a, b);
      chk({nm, " o_valid after 1 cycle"}, 32'(o_valid), 32'd0);
      @(posedge clk); #1;
      chk({nm, " o_valid after 2 cycles"}, 32'(o_valid), 32'd1);
      cmp_dut(nm, req);
      @(posedge clk); #1;
   endtask

   logic [31:0] ta [8] = '{32'h3F800000, 32'h40490FDB, 32'hC2C80000, 32'h00400000,
                           32'h7F7FFFFF, 32'h3F800000, 32'h80000000, 32'h41200000};
   logic [31:0] tb [8] = '{32'hBF800000, 32'h3EAAAAAB, 32'h42C80000, 32'h80400001,
                           32'h7F7FFFFF, 32'h00000001, 32'h00000000, 32'hC1200001};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      res_t p1, p2, p3;
      logic acc;

      // Reset state
      #1 rst_n = 1'b0;
      #2;
      chk("reset o_valid", 32'(o_valid), 32'd0);
      chk("reset o_ready", 32'(o_ready), 32'd1);
      cmp_dut("reset", mk(32'h0, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("after release o_ready", 32'(o_ready), 32'd1);

      // Directed vectors
      directed("equal", 32'h3F800000, 32'h3F800000,
               mk(32'h04000000, 32'h04000000, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0));
      directed("sub swap", 32'h3F000000, 32'hBF800000,
               mk(32'h04000000, 32'hFDFFFFFF, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0));
      directed("sticky d30", 32'h3F800000, 32'h30800001,
               mk(32'h04000000, 32'h00000001, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0));
      directed("shift d25", 32'h3F800000, 32'h33000001,
               mk(32'h04000000, 32'h00000003, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0));
      directed("tie opp sign", 32'h3F800000, 32'hBF800000,
               mk(32'h04000000, 32'hFBFFFFFF, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0));
      directed("denormal", 32'h00000001, 32'h80000000,
               mk(32'h00000008, 32'hFFFFFFFF, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0));
      directed("inf-inf", 32'h7F800000, 32'hFF800000,
               mk(32'h04000000, 32'hFBFFFFFF, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0));
      directed("nan", 32'h7FC00000, 32'h3F800000,
               mk(32'h06000000, 32'h00000001, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0));
      directed("inf+1", 32'h7F800000, 32'h3F800000,
               mk(32'h04000000, 32'h00000001, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1));
      directed("1-inf", 32'h3F800000, 32'hFF800000,
               mk(32'h04000000, 32'hFFFFFFFE, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1));

      // Backpressure: three back-to-back offers against a stalled consumer
      p1 = model(32'h3F800000, 32'h3F000000);
      p2 = model(32'h40000000, 32'h3F000000);
      p3 = model(32'h40800000, 32'h3F000000);
      i_ready = 1'b0;
      op_a = 32'h3F800000; op_b = 32'h3F000000; i_valid = 1'b1;
      chk("bp cycle1 o_ready", 32'(o_ready), 32'd1);
      @(posedge clk); #1;
      chk("bp cycle2 o_ready", 32'(o_ready), 32'd1);
      chk("bp cycle2 o_valid", 32'(o_valid), 32'd0);
      op_a = 32'h40000000;
      @(posedge clk); #1;
      op_a = 32'h40800000;
      for (int k = 0; k < 4; k++) begin
         chk("bp stalled o_ready", 32'(o_ready), 32'd0);
         chk("bp stalled o_valid", 32'(o_valid), 32'd1);
         chk("bp frozen o_a", o_a, p1.a);
         chk("bp frozen o_exp", 32'(o_exp), 32'(p1.e));
         @(posedge clk); #1;
      end
      i_ready = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      chk("bp drain 2nd o_exp", 32'(o_exp), 32'(p2.e));
      @(posedge clk); #1;
      chk("bp drain 3rd o_valid", 32'(o_valid), 32'd1);
      chk("bp drain 3rd o_exp", 32'(o_exp), 32'(p3.e));
      @(posedge clk); #1;
      chk("bp drained o_valid", 32'(o_valid), 32'd0);

      // Stream with a rotating backpressure pattern
      for (int k = 0; k < 8; k++) begin
         op_a = ta[k]; op_b = tb[k]; i_valid = 1'b1;
         acc = 1'b0;
         for (int g = 0; g < 20 && !acc; g++) begin
            i_ready = ((k + g) % 3) != 1;
            @(negedge clk);
            acc = o_ready;
            @(posedge clk); #1;
         end
         chk("stream accepted", 32'(acc), 32'd1);
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      for (int g = 0; g < 20 && (q.size() != 0 || o_valid); g++) begin
         @(posedge clk); #1;
      end
      chk("stream queue empty", 32'(q.size()), 32'd0);
      chk("stream in/out count", 32'(n_out), 32'(n_in));

      // Reset with both stages full
      i_ready = 1'b0;
      send(32'h3F000000, 32'hBF800000);
      send(32'h3F800000, 32'hBF800000);
      chk("pre-reset o_valid", 32'(o_valid), 32'd1);
      chk("pre-reset o_ready", 32'(o_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("async reset o_valid", 32'(o_valid), 32'd0);
      chk("async reset o_ready", 32'(o_ready), 32'd1);
      cmp_dut("async reset", mk(32'h0, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
      @(negedge clk);
      @(posedge clk); #1;
      rst_n   = 1'b1;
      i_ready = 1'b1;
      directed("post reset", 32'h3F800000, 32'h3F800000,
               mk(32'h04000000, 32'h04000000, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0));
      @(posedge clk); #1;
      chk("final queue empty", 32'(q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
